// File: rtl/param_counter_compare_if.sv
// Bus bundle for param_counter_compare.
// master drives controls, slave is the counter.
interface param_counter_compare_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_CMP = 2
) ();
  logic                     enable;
  logic                     load;
  logic [WIDTH-1:0]         load_value;
  logic                     up_down;
  logic                     one_shot;
  logic [WIDTH-1:0]         modulus;
  logic [NUM_CMP*WIDTH-1:0] cmp_value;
  logic [NUM_CMP-1:0]       cmp_clear;
  logic [WIDTH-1:0]         count;
  logic [NUM_CMP-1:0]       match;
  logic [NUM_CMP-1:0]       match_flag;
  logic                     wrap;
  logic                     busy;
  logic                     done;

  modport master (
    output enable, load, load_value, up_down,
    output one_shot, modulus, cmp_value, cmp_clear,
    input  count, match, match_flag, wrap, busy, done
  );

  modport slave (
    input  enable, load, load_value, up_down,
    input  one_shot, modulus, cmp_value, cmp_clear,
    output count, match, match_flag, wrap, busy, done
  );
endinterface

// File: rtl/param_counter_compare.sv
// Up/down modulo counter with one-shot DONE state
// and NUM_CMP live/sticky compare channels.
module param_counter_compare #(
  parameter int WIDTH   = 8,
  parameter int NUM_CMP = 2
) (
  input logic clk,
  input logic reset,
  param_counter_compare_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_n;
  logic [WIDTH-1:0]   count_q;
  logic [WIDTH-1:0]   count_n;
  logic [WIDTH-1:0]   step_val;
  logic [WIDTH-1:0]   term;
  logic [WIDTH-1:0]   load_sat;
  logic               step_wrap;
  logic               at_term;
  logic               wrap_q;
  logic               wrap_n;
  logic [NUM_CMP-1:0] match;
  logic [NUM_CMP-1:0] flag_q;

  // Free-run step result and terminal detection for the current direction
  always_comb begin
    step_val  = count_q;
    step_wrap = 1'b0;
    if (bus.up_down) begin
      term    = bus.modulus;
      at_term = (count_q >= bus.modulus);
      if (count_q >= bus.modulus) begin
        step_val  = '0;
        step_wrap = 1'b1;
      end else begin
        step_val = count_q + 1'b1;
      end
    end else begin
      term    = '0;
      at_term = (count_q == '0);
      if (count_q == '0) begin
        step_val  = bus.modulus;
        step_wrap = 1'b1;
      end else if (count_q > bus.modulus) begin
        step_val = bus.modulus;
      end else begin
        step_val = count_q - 1'b1;
      end
    end
  end

  // Load value clamped into the count range
  always_comb begin
    load_sat = bus.load_value;
    if (bus.load_value > bus.modulus) begin
      load_sat = bus.modulus;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state: load forces IDLE, DONE only exits via load/reset
  always_comb begin
    state_n = state;
    if (bus.load) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE, RUN: begin
          if (!bus.enable) begin
            state_n = IDLE;
          end else if (bus.one_shot &&
                       (at_term || step_val == term)) begin
            state_n = DONE;
          end else begin
            state_n = RUN;
          end
        end
        DONE:    state_n = DONE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Next count and wrap pulse
  always_comb begin
    count_n = count_q;
    wrap_n  = 1'b0;
    if (bus.load) begin
      count_n = load_sat;
    end else if (state != DONE && bus.enable) begin
      if (bus.one_shot) begin
        count_n = at_term ? term : step_val;
      end else begin
        count_n = step_val;
        wrap_n  = step_wrap;
      end
    end
  end

  // Count, wrap and sticky match flags
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      flag_q  <= '0;
    end else begin
      count_q <= count_n;
      wrap_q  <= wrap_n;
      flag_q  <= (flag_q & ~bus.cmp_clear) | match;
    end
  end

  // Live compare per channel
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_CMP; i++) begin
      match[i] = (count_q == bus.cmp_value[i*WIDTH +: WIDTH]);
    end
  end

  // Outputs decoded from registered state
  always_comb begin
    bus.count      = count_q;
    bus.wrap       = wrap_q;
    bus.match      = match;
    bus.match_flag = flag_q;
    bus.busy       = (state == RUN);
    bus.done       = (state == DONE);
  end
endmodule

// File: tb/tb_param_counter_compare.sv
// Directed bench for param_counter_compare.
// Inputs change 1ns after posedge; outputs sampled there.
module tb_param_counter_compare;
  localparam int W = 8;
  localparam int N = 2;

  logic clk;
  logic reset;
  int   total;
  int   passed;

  param_counter_compare_if #(.WIDTH(W), .NUM_CMP(N)) bus ();

  param_counter_compare #(.WIDTH(W), .NUM_CMP(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.enable = 1'b0; bus.load = 1'b0;
    bus.load_value = '0; bus.up_down = 1'b1;
    bus.one_shot = 1'b0; bus.modulus = 8'd5;
    bus.cmp_value = {8'hFF, 8'hFF};
    bus.cmp_clear = '0;
    do_reset();
    total++;
    if (bus.count !== 8'd0 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0 || bus.wrap !== 1'b0 ||
        bus.match_flag !== 2'b00)
      $display("FAIL reset: cnt=%0d busy=%b done=%b wrap=%b flag=%b want 0",
               bus.count, bus.busy, bus.done, bus.wrap, bus.match_flag);
    else passed++;
  endtask

  task automatic test_free_run_up();
    logic [7:0] exp_c [8] = '{1, 2, 3, 4, 5, 0, 1, 2};
    bus.enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      total++;
      if (bus.count !== exp_c[i] || bus.wrap !== (i == 5) ||
          bus.busy !== 1'b1)
        $display("FAIL up_run[%0d]: cnt=%0d wrap=%b busy=%b want %0d %b 1",
                 i, bus.count, bus.wrap, bus.busy, exp_c[i], (i == 5));
      else passed++;
    end
    bus.enable = 1'b0;
    step();
    total++;
    if (bus.count !== 8'd2 || bus.busy !== 1'b0)
      $display("FAIL up_pause: cnt=%0d busy=%b want 2 0",
               bus.count, bus.busy);
    else passed++;
  endtask

  task automatic test_one_shot_down();
    logic [7:0] exp_c [3] = '{2, 1, 0};
    do_reset();
    bus.modulus = 8'd10; bus.up_down = 1'b0;
    bus.one_shot = 1'b1;
    bus.load = 1'b1; bus.load_value = 8'd3;
    step();
    bus.load = 1'b0;
    total++;
    if (bus.count !== 8'd3 || bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL os_load: cnt=%0d busy=%b done=%b want 3 0 0",
               bus.count, bus.busy, bus.done);
    else passed++;
    bus.enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (bus.count !== exp_c[i] || bus.done !== (i == 2) ||
          bus.busy !== (i != 2) || bus.wrap !== 1'b0)
        $display("FAIL os_down[%0d]: cnt=%0d done=%b busy=%b wrap=%b want %0d",
                 i, bus.count, bus.done, bus.busy, bus.wrap, exp_c[i]);
      else passed++;
    end
    bus.up_down = 1'b1; bus.one_shot = 1'b0;
    step();
    total++;
    if (bus.count !== 8'd0 || bus.done !== 1'b1 || bus.wrap !== 1'b0)
      $display("FAIL os_hold: cnt=%0d done=%b wrap=%b want 0 1 0",
               bus.count, bus.done, bus.wrap);
    else passed++;
    bus.load = 1'b1; bus.load_value = 8'd7;
    step();
    bus.load = 1'b0; bus.enable = 1'b0;
    total++;
    if (bus.count !== 8'd7 || bus.done !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL os_reload: cnt=%0d done=%b busy=%b want 7 0 0",
               bus.count, bus.done, bus.busy);
    else passed++;
  endtask

  task automatic test_one_shot_up();
    do_reset();
    bus.modulus = 8'd2; bus.up_down = 1'b1;
    bus.one_shot = 1'b1; bus.enable = 1'b1;
    step();
    step();
    total++;
    if (bus.count !== 8'd2 || bus.done !== 1'b1)
      $display("FAIL os_up: cnt=%0d done=%b want 2 1",
               bus.count, bus.done);
    else passed++;
    step();
    total++;
    if (bus.count !== 8'd2 || bus.wrap !== 1'b0)
      $display("FAIL os_up_hold: cnt=%0d wrap=%b want 2 0",
               bus.count, bus.wrap);
    else passed++;
    bus.enable = 1'b0; bus.one_shot = 1'b0;
  endtask

  task automatic test_compare();
    do_reset();
    bus.modulus = 8'd10; bus.up_down = 1'b1;
    bus.one_shot = 1'b0;
    bus.cmp_value = {8'd2, 8'd4};
    bus.enable = 1'b1;
    step();
    total++;
    if (bus.count !== 8'd1 || bus.match !== 2'b00)
      $display("FAIL cmp_c1: cnt=%0d match=%b want 1 00",
               bus.count, bus.match);
    else passed++;
    step();
    total++;
    if (bus.match !== 2'b10 || bus.match_flag !== 2'b00)
      $display("FAIL cmp_c2: match=%b flag=%b want 10 00",
               bus.match, bus.match_flag);
    else passed++;
    step();
    total++;
    if (bus.match !== 2'b00 || bus.match_flag !== 2'b10)
      $display("FAIL cmp_c3: match=%b flag=%b want 00 10",
               bus.match, bus.match_flag);
    else passed++;
    step();
    total++;
    if (bus.count !== 8'd4 || bus.match !== 2'b01 ||
        bus.match_flag !== 2'b10)
      $display("FAIL cmp_c4: cnt=%0d match=%b flag=%b want 4 01 10",
               bus.count, bus.match, bus.match_flag);
    else passed++;
    bus.cmp_clear = 2'b01;
    step();
    bus.cmp_clear = 2'b00;
    total++;
    if (bus.match_flag !== 2'b11)
      $display("FAIL cmp_setwins: flag=%b want 11", bus.match_flag);
    else passed++;
    bus.enable = 1'b0;
    bus.cmp_clear = 2'b11;
    step();
    bus.cmp_clear = 2'b00;
    total++;
    if (bus.match_flag !== 2'b00 || bus.count !== 8'd5)
      $display("FAIL cmp_clear: flag=%b cnt=%0d want 00 5",
               bus.match_flag, bus.count);
    else passed++;
    bus.cmp_value = {8'hFF, 8'hFF};
  endtask

  task automatic test_pause_resume();
    logic       en_seq [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0] exp_c  [4] = '{1, 1, 1, 2};
    do_reset();
    bus.modulus = 8'd10; bus.up_down = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.enable = en_seq[i];
      step();
      total++;
      if (bus.count !== exp_c[i] || bus.busy !== en_seq[i])
        $display("FAIL pause[%0d]: cnt=%0d busy=%b want %0d %b",
                 i, bus.count, bus.busy, exp_c[i], en_seq[i]);
      else passed++;
    end
    bus.enable = 1'b1; bus.load = 1'b1;
    bus.load_value = 8'd4;
    step();
    bus.load = 1'b0; bus.enable = 1'b0;
    total++;
    if (bus.count !== 8'd4 || bus.busy !== 1'b0)
      $display("FAIL load_wins: cnt=%0d busy=%b want 4 0",
               bus.count, bus.busy);
    else passed++;
  endtask

  task automatic test_modulus_bounds();
    do_reset();
    bus.modulus = 8'd10; bus.up_down = 1'b1;
    bus.load = 1'b1; bus.load_value = 8'd9;
    step();
    bus.load = 1'b0;
    bus.modulus = 8'd6; bus.enable = 1'b1;
    step();
    total++;
    if (bus.count !== 8'd0 || bus.wrap !== 1'b1)
      $display("FAIL mod_lower: cnt=%0d wrap=%b want 0 1",
               bus.count, bus.wrap);
    else passed++;
    bus.enable = 1'b0; bus.load = 1'b1;
    bus.load_value = 8'd12;
    step();
    total++;
    if (bus.count !== 8'd6)
      $display("FAIL load_clamp: cnt=%0d want 6", bus.count);
    else passed++;
    bus.modulus = 8'd10; bus.load_value = 8'd9;
    step();
    bus.load = 1'b0;
    bus.modulus = 8'd6; bus.up_down = 1'b0;
    bus.enable = 1'b1;
    step();
    total++;
    if (bus.count !== 8'd6 || bus.wrap !== 1'b0)
      $display("FAIL down_clamp: cnt=%0d wrap=%b want 6 0",
               bus.count, bus.wrap);
    else passed++;
    bus.load = 1'b1; bus.load_value = 8'd0;
    step();
    bus.load = 1'b0;
    step();
    total++;
    if (bus.count !== 8'd6 || bus.wrap !== 1'b1)
      $display("FAIL down_wrap: cnt=%0d wrap=%b want 6 1",
               bus.count, bus.wrap);
    else passed++;
    bus.modulus = 8'd0; bus.up_down = 1'b1;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (bus.count !== 8'd0 || bus.wrap !== 1'b1)
        $display("FAIL mod0[%0d]: cnt=%0d wrap=%b want 0 1",
                 i, bus.count, bus.wrap);
      else passed++;
    end
    bus.enable = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    bus.modulus = 8'd10; bus.up_down = 1'b1;
    bus.one_shot = 1'b0;
    bus.cmp_value = {8'hFF, 8'd2};
    bus.enable = 1'b1;
    step(); step(); step();
    total++;
    if (bus.count !== 8'd3 || bus.busy !== 1'b1 ||
        bus.match_flag !== 2'b01)
      $display("FAIL pre_rst: cnt=%0d busy=%b flag=%b want 3 1 01",
               bus.count, bus.busy, bus.match_flag);
    else passed++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.enable = 1'b0;
    total++;
    if (bus.count !== 8'd0 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0 || bus.match_flag !== 2'b00 ||
        bus.wrap !== 1'b0)
      $display("FAIL mid_rst: cnt=%0d busy=%b done=%b flag=%b want 0",
               bus.count, bus.busy, bus.done, bus.match_flag);
    else passed++;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    reset  = 1'b1;
    #1;
    test_reset();
    test_free_run_up();
    test_one_shot_down();
    test_one_shot_up();
    test_compare();
    test_pause_resume();
    test_modulus_bounds();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
